// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: config, control, serial data and status bundle.
// master drives cfg/start/stop/din; slave returns dout/count/busy/done.
interface pattern_scan_ctrl_if #(
  parameter int PW = 8,
  parameter int CW = 8
);
  logic          cfg_we;
  logic [PW-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic          cfg_overlap;
  logic [CW-1:0] cfg_target;
  logic          start;
  logic          stop;
  logic          din;
  logic          din_valid;
  logic          dout;
  logic [CW-1:0] match_count;
  logic          busy;
  logic          done;

  modport master (
    output cfg_we, cfg_pattern, cfg_len,
    output cfg_overlap, cfg_target,
    output start, stop, din, din_valid,
    input  dout, match_count, busy, done
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len,
    input  cfg_overlap, cfg_target,
    input  start, stop, din, din_valid,
    output dout, match_count, busy, done
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serial pattern matcher, IDLE/SCAN/DONE control.
// Ports: clk, rst (async low), bus (slave): cfg, start/stop, din, status.
module pattern_scan_ctrl #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input logic               clk,
  input logic               rst,
  pattern_scan_ctrl_if.slave bus
);

  localparam int SW = $clog2(PW + 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  state_e        state_q;
  logic [PW-1:0] pat_q;
  logic [3:0]    len_q;
  logic          ovl_q;
  logic [CW-1:0] tgt_q;
  logic [PW-2:0] hist_q;
  logic [SW-1:0] seen_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  logic [PW-1:0] win;
  logic [PW-1:0] mask;
  logic [SW-1:0] eff_len;
  logic [PW-2:0] hist_d;
  logic [SW-1:0] seen_d;
  logic [CW-1:0] cnt_d;
  logic          seen_ok;
  logic          hit;
  logic          hit_tgt;

  always_comb begin
    eff_len = SW'(len_q);
    if (len_q == 4'd0) begin
      eff_len = SW'(1);
    end else if (int'(len_q) > PW) begin
      eff_len = SW'(PW);
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PW; i++) begin
      mask[i] = (i < int'(eff_len));
    end
  end

  // Newest bit sits in bit 0, matching pattern bit 0 = last serial bit.
  assign win = {hist_q, bus.din};
  assign hist_d = win[PW-2:0];

  assign seen_ok = ({1'b0, seen_q} + (SW+1)'(1))
                   >= {1'b0, eff_len};

  assign hit = (state_q == SCAN) && bus.din_valid
               && seen_ok
               && (((win ^ pat_q) & mask) == '0);

  assign cnt_d = (cnt_q == '1) ? cnt_q
                 : cnt_q + CW'(1);

  assign hit_tgt = hit && (tgt_q != '0)
                   && ((cnt_q + CW'(1)) == tgt_q);

  // Non-overlap mode restarts the fill count after a hit.
  always_comb begin
    seen_d = seen_q;
    if (hit && !ovl_q) begin
      seen_d = '0;
    end else if (int'(seen_q) != PW) begin
      seen_d = seen_q + SW'(1);
    end
  end

  assign bus.dout        = hit;
  assign bus.match_count = cnt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      hist_q  <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cfg_we) begin
            pat_q <= bus.cfg_pattern;
            len_q <= bus.cfg_len;
            ovl_q <= bus.cfg_overlap;
            tgt_q <= bus.cfg_target;
          end
          if (bus.start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            hist_q  <= '0;
            seen_q  <= '0;
          end
        end
        SCAN: begin
          if (bus.din_valid) begin
            hist_q <= hist_d;
            seen_q <= seen_d;
          end
          if (hit) begin
            cnt_q <= cnt_d;
          end
          if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (hit_tgt) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (bus.stop) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else if (bus.start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            hist_q  <= '0;
            seen_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed streams, queued expectations.
// A negedge monitor pops one expected record per driven cycle.
module tb_pattern_scan_ctrl;

  typedef struct packed {
    logic       d;
    logic [7:0] c;
    logic       b;
    logic       n;
  } exp_t;

  logic clk;
  logic rst;

  pattern_scan_ctrl_if #(.PW(8), .CW(8)) bus ();

  pattern_scan_ctrl #(.PW(8), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] m_cnt  = 8'd0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = '{bus.dout, bus.match_count,
            bus.busy, bus.done};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL vec%0d: got dout=%b cnt=%0d busy=%b done=%b, need dout=%b cnt=%0d busy=%b done=%b",
                 n_vec, a.d, a.c, a.b, a.n,
                 e.d, e.c, e.b, e.n);
      end
    end
  end

  // One clock cycle: drive, queue the expected view, advance.
  task automatic cyc(input logic d, input logic dv,
                     input logic st, input logic sp,
                     input logic we, input logic ed);
    bus.din       = d;
    bus.din_valid = dv;
    bus.start     = st;
    bus.stop      = sp;
    bus.cfg_we    = we;
    sb_q.push_back('{ed, m_cnt, m_busy, m_done});
    @(posedge clk);
    #1;
    if (ed && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    if (sp && (m_busy || m_done)) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (st && !m_busy) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_cnt  = 8'd0;
    end
  endtask

  task automatic cfg(input logic [7:0] p,
                     input logic [3:0] l,
                     input logic o,
                     input logic [7:0] t,
                     input logic st);
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    bus.cfg_target  = t;
    cyc(1'b0, 1'b0, st, 1'b0, 1'b1, 1'b0);
  endtask

  // Sends b[n-1] first; e holds the expected dout per bit.
  task automatic stream(input logic [15:0] b,
                        input logic [15:0] e,
                        input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(b[i], 1'b1, 1'b0, 1'b0, 1'b0, e[i]);
    end
  endtask

  task automatic stop_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst             = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = 8'h00;
    bus.cfg_len     = 4'd0;
    bus.cfg_overlap = 1'b0;
    bus.cfg_target  = 8'h00;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.din         = 1'b0;
    bus.din_valid   = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    m_busy = 1'b0;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Overlap on, cfg and start in the same cycle
    cfg(8'b001001, 4'd6, 1'b1, 8'd0, 1'b1);
    stream(16'b001001001, 16'b000001001, 9);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    stop_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Overlap off
    cfg(8'b001001, 4'd6, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    stream(16'b001001001001, 16'b000001000001, 12);
    stop_cyc();

    // Target 2 reaches DONE; DONE ignores din; start clears
    cfg(8'b001001, 4'd6, 1'b1, 8'd2, 1'b1);
    stream(16'b001001001, 16'b000001001, 9);
    m_busy = 1'b0;
    m_done = 1'b1;
    stream(16'b001, 16'b000, 3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stop_cyc();

    // din_valid bubbles
    cfg(8'b001001, 4'd6, 1'b1, 8'd0, 1'b1);
    stream(16'b0, 16'b0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(16'b0, 16'b0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(16'b1, 16'b0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(16'b00, 16'b00, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(16'b1, 16'b1, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stop_cyc();

    // cfg_we in SCAN ignored; stop on match beats target DONE
    cfg(8'b001001, 4'd6, 1'b1, 8'd1, 1'b1);
    bus.cfg_pattern = 8'hFF;
    bus.cfg_len     = 4'd1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    stream(16'b00100, 16'b00000, 5);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // cfg_len above PW clamps to 8
    cfg(8'hA5, 4'd15, 1'b1, 8'd0, 1'b1);
    stream(16'b10100101, 16'b00000001, 8);
    stop_cyc();

    // L=1 (cfg_len=0), saturation, async reset mid-stream
    cfg(8'h01, 4'd0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    rst    = 1'b0;
    m_cnt  = 8'd0;
    m_busy = 1'b0;
    m_done = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset config: pattern 0, L=1
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    stream(16'b01, 16'b10, 2);
    stop_cyc();

    @(posedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d left, need 0",
               sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
